axi_lite_cmd_queue: RTL

AXI_LITE_CMD_QUEUE -- requirements
Module: axi_lite_cmd_queue

---
 rtl/axi_lite_cmdq_pkg.sv | 19 +
 rtl/axi_lite_sync_fifo.sv | 68 ++++++
 rtl/axi_lite_cmd_queue.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/axi_lite_cmdq_pkg.sv
// rtl/axi_lite_cmdq_pkg.sv - FSM state encodings and response codes shared by the command queue
package axi_lite_cmdq_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   localparam int STRB_W = 4;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      WAIT  = ST_WAIT,
      RESP  = ST_RESP
   } state_t;
endpackage

// File: rtl/axi_lite_sync_fifo.sv
// rtl/axi_lite_sync_fifo.sv - single-clock FIFO; pushes on full and pops on empty are ignored
module axi_lite_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/axi_lite_cmd_queue.sv
// rtl/axi_lite_cmd_queue.sv - queued single-outstanding command issuer with held responses
// Define AXI_CMDQ_TIMEOUT_EN to add a WAIT-state watchdog that returns a timeout response.
module axi_lite_cmd_queue
   import axi_lite_cmdq_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_wr,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr,
   input  logic [DATA_WIDTH-1:0]  cmd_wdata,
   input  logic [STRB_W-1:0]      cmd_wstrb,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_wr,
   output logic                   rsp_ok,
   output logic                   rsp_timeout,
   output logic [DATA_WIDTH-1:0]  rsp_rdata,
   output logic                   m_req,
   output logic                   m_wr,
   output logic [ADDR_WIDTH-1:0]  m_addr,
   output logic [DATA_WIDTH-1:0]  m_wdata,
   output logic [STRB_W-1:0]      m_wstrb,
   input  logic                   m_ready,
   input  logic                   m_resp_ok,
   input  logic [DATA_WIDTH-1:0]  m_rdata,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);
   localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;

   state_t                state_q, state_d;
   logic [1:0]            rsp_code_q, rsp_code_d;
   logic                  rsp_wr_q, rsp_wr_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [ENT_W-1:0]      head;
   logic                  head_wr;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_wdata;
   logic [STRB_W-1:0]     head_wstrb;
   logic                  full, empty, pop, active, timeout_hit;

   axi_lite_sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .wdata ({cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign {head_wr, head_addr, head_wdata, head_wstrb} = head;

`ifdef AXI_CMDQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             rsp_timeout_q, rsp_timeout_d;

   assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
   assign rsp_timeout = rsp_valid && rsp_timeout_q;

   // m_ready beats a coincident watchdog expiry.
   always_comb begin
      wait_cnt_d    = wait_cnt_q;
      rsp_timeout_d = rsp_timeout_q;
      if (state_q == ISSUE) begin
         wait_cnt_d = '0;
      end else if (state_q == WAIT && !timeout_hit) begin
         wait_cnt_d = wait_cnt_q + TMO_W'(1);
      end
      if (active && m_ready) begin
         rsp_timeout_d = 1'b0;
      end else if (timeout_hit) begin
         rsp_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q    <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   assign active = (state_q == ISSUE) || (state_q == WAIT);

   always_comb begin
      state_d     = state_q;
      rsp_code_d  = rsp_code_q;
      rsp_wr_d    = rsp_wr_q;
      rsp_rdata_d = rsp_rdata_q;
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) state_d = ISSUE;
         end
         ISSUE, WAIT: begin
            if (m_ready) begin
               rsp_code_d  = m_resp_ok ? OKAY : SLVERR;
               rsp_wr_d    = head_wr;
               rsp_rdata_d = head_wr ? '0 : m_rdata;
               state_d     = RESP;
            end else if (timeout_hit) begin
               rsp_code_d  = SLVERR;
               rsp_wr_d    = head_wr;
               rsp_rdata_d = '0;
               state_d     = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               pop     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rsp_code_q  <= SLVERR;
         rsp_wr_q    <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rsp_code_q  <= rsp_code_d;
         rsp_wr_q    <= rsp_wr_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // The head entry stays put until the RESP pop, so the master fields are stable across WAIT.
   assign cmd_ready = !full;
   assign busy      = (state_q != IDLE);
   assign m_req     = (state_q == ISSUE);
   assign m_wr      = active && head_wr;
   assign m_addr    = active ? head_addr  : '0;
   assign m_wdata   = active ? head_wdata : '0;
   assign m_wstrb   = active ? head_wstrb : '0;
   assign rsp_valid = (state_q == RESP);
   assign rsp_ok    = rsp_valid && (rsp_code_q == OKAY);
   assign rsp_wr    = rsp_valid && rsp_wr_q;
   assign rsp_rdata = rsp_valid ? rsp_rdata_q : '0;
endmodule
